// File: rtl/irq_timer_pkg.sv
// rtl/irq_timer_pkg.sv - shared encodings for the interrupt timer
package irq_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - countdown timer with CTRL/PRESET/COUNT registers and masked interrupt
module irq_timer
  import irq_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;

  logic [31:0] w_count_nxt;
  logic        w_flag_set;
  logic        w_flag_clr;
  logic        w_en_clr;
  logic        w_ctrl_wr;
  logic        w_preset_wr;

  assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
  assign w_preset_wr = we && (addr == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flag_set  = 1'b0;
    w_flag_clr  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: if (r_en) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // Terminal count of 0 or 1 both land on 0; never wrap.
          w_count_nxt = 32'd0;
          w_flag_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (r_mode == MODE_AUTO) w_flag_clr = 1'b1;
        else                     w_en_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_mode   <= MODE_ONESHOT;
      r_im     <= 1'b0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_flag   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // A bus write to CTRL overrides the one-shot EN clear in the same cycle.
      if (w_ctrl_wr) begin
        r_en   <= wdata[CTRL_EN_BIT];
        r_mode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im   <= wdata[CTRL_IM_BIT];
      end else if (w_en_clr) begin
        r_en <= 1'b0;
      end
      if (w_preset_wr) r_preset <= wdata;
      if (w_ctrl_wr || w_preset_wr) r_flag <= 1'b0;
      else if (w_flag_set)          r_flag <= 1'b1;
      else if (w_flag_clr)          r_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
      ADDR_PRESET: rdata = r_preset;
      ADDR_COUNT:  rdata = r_count;
      ADDR_RSVD:   rdata = 32'd0;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = r_flag & r_im;

endmodule

// File: tb/tb_irq_timer.sv
// tb/tb_irq_timer.sv - self-checking bench for irq_timer: directed scenarios plus random traffic vs reference model
module tb_irq_timer;
  import irq_timer_pkg::ADDR_CTRL, irq_timer_pkg::ADDR_PRESET, irq_timer_pkg::ADDR_COUNT, irq_timer_pkg::ADDR_RSVD;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: timer activity phases described by plain integers.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COUNT = 2, PH_FIRED = 3;
  int          m_phase;
  bit          m_en, m_im, m_flag, m_valid;
  bit   [1:0]  m_mode;
  longint      m_preset, m_count;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset[31:0];
      2'd2:    return m_count[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input logic w, input logic [1:0] a, input logic [31:0] d);
    bit set_f = 0, clr_f = 0, drop_en = 0;
    if (rst) begin
      m_phase = PH_IDLE; m_en = 0; m_mode = 0; m_im = 0;
      m_preset = 0; m_count = 0; m_flag = 0;
      return;
    end
    if (m_phase == PH_IDLE) begin
      if (m_en) m_phase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      m_count = m_preset; m_phase = PH_COUNT;
    end else if (m_phase == PH_COUNT) begin
      if (!m_en) m_phase = PH_IDLE;
      else if (m_count >= 2) m_count = m_count - 1;
      else begin m_count = 0; set_f = 1; m_phase = PH_FIRED; end
    end else begin
      if (m_mode == 2'b01) clr_f = 1; else drop_en = 1;
      m_phase = PH_IDLE;
    end
    if (drop_en) m_en = 0;
    if (w && a == 2'd0) begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
    if (w && a == 2'd1) m_preset = d;
    if (w && (a == 2'd0 || a == 2'd1)) m_flag = 0;
    else if (set_f) m_flag = 1;
    else if (clr_f) m_flag = 0;
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, compare against the model before the edge, clock, advance model.
  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    #1;
    if (m_valid) begin
      check32("model_rdata", rdata, model_read(a));
      check32("model_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    end
    @(posedge clk);
    model_step(reset, w, a, d);
    m_valid = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, ADDR_COUNT, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a; #1;
    check32(tag, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, ADDR_PRESET, 32'hDEAD_BEEF);
    reset = 1'b0;
  endtask

  initial begin
    bit irq_seen;
    m_valid = 0;
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 2'd0, 32'd0);
    m_valid = 1;
    @(negedge clk);
    do_reset();
    rd("reset_ctrl", ADDR_CTRL, 32'd0);
    rd("reset_preset", ADDR_PRESET, 32'd0);
    rd("reset_count", ADDR_COUNT, 32'd0);
    check32("reset_irq", {31'd0, irq}, 32'd0);

    // One-shot countdown from 3 with the mask open.
    cyc(1'b1, ADDR_PRESET, 32'd3);
    cyc(1'b1, ADDR_CTRL, 32'h9);
    idle(2); rd("os_cnt3", ADDR_COUNT, 32'd3);
    idle(1); rd("os_cnt2", ADDR_COUNT, 32'd2);
    idle(1); rd("os_cnt1", ADDR_COUNT, 32'd1);
    idle(1); rd("os_cnt0", ADDR_COUNT, 32'd0);
    check32("os_irq_set", {31'd0, irq}, 32'd1);
    idle(1); rd("os_ctrl_en_clr", ADDR_CTRL, 32'h8);
    idle(3); check32("os_irq_held", {31'd0, irq}, 32'd1);

    // Rewriting CTRL clears the flag and restarts the countdown.
    cyc(1'b1, ADDR_CTRL, 32'h9);
    check32("rearm_irq_drop", {31'd0, irq}, 32'd0);
    idle(2); rd("rearm_cnt3", ADDR_COUNT, 32'd3);
    idle(3); check32("rearm_irq", {31'd0, irq}, 32'd1);

    // Auto-reload: P=2 gives a one-cycle pulse every 5 cycles.
    do_reset();
    cyc(1'b1, ADDR_PRESET, 32'd2);
    cyc(1'b1, ADDR_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      check32($sformatf("auto_irq_k%0d", k), {31'd0, irq}, {31'd0, (k >= 4 && (k - 4) % 5 == 0)});
    end
    rd("auto_ctrl_kept", ADDR_CTRL, 32'hB);

    // Masked interrupt with P=0: flag sets but irq never rises, CTRL write clears it.
    do_reset();
    cyc(1'b1, ADDR_PRESET, 32'd0);
    cyc(1'b1, ADDR_CTRL, 32'h1);
    irq_seen = 0;
    for (int k = 0; k < 5; k++) begin idle(1); irq_seen |= irq; end
    check32("mask_irq_low", {31'd0, irq_seen}, 32'd0);
    rd("mask_en_clr", ADDR_CTRL, 32'd0);
    cyc(1'b1, ADDR_CTRL, 32'h8);
    idle(2); check32("mask_after_unmask", {31'd0, irq}, 32'd0);

    // Disable mid-count freezes COUNT; PRESET writes don't touch it.
    do_reset();
    cyc(1'b1, ADDR_PRESET, 32'd10);
    cyc(1'b1, ADDR_CTRL, 32'h1);
    idle(4); rd("mid_cnt8", ADDR_COUNT, 32'd8);
    cyc(1'b1, ADDR_CTRL, 32'h0);
    idle(3); rd("mid_frozen", ADDR_COUNT, 32'd7);
    cyc(1'b1, ADDR_PRESET, 32'd20);
    idle(2); rd("mid_preset_nochg", ADDR_COUNT, 32'd7);
    cyc(1'b1, ADDR_COUNT, 32'hFFFF_FFFF);
    rd("count_ro", ADDR_COUNT, 32'd7);
    cyc(1'b1, ADDR_CTRL, 32'hFFFF_FFF8);
    rd("ctrl_upper_zero", ADDR_CTRL, 32'h8);
    rd("rsvd_zero", ADDR_RSVD, 32'd0);
    cyc(1'b1, ADDR_CTRL, 32'h9);
    idle(5);
    do_reset();
    rd("rst_mid_ctrl", ADDR_CTRL, 32'd0);
    rd("rst_mid_preset", ADDR_PRESET, 32'd0);
    rd("rst_mid_count", ADDR_COUNT, 32'd0);
    check32("rst_mid_irq", {31'd0, irq}, 32'd0);

    // Random bus traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      logic        w;
      a = 2'($urandom_range(3));
      w = ($urandom_range(3) == 0);
      if (a == ADDR_CTRL)        d = {$urandom_range(1) == 0 ? 28'd0 : 28'($urandom), 4'($urandom)};
      else if (a == ADDR_PRESET) d = 32'($urandom_range(6));
      else                       d = $urandom;
      reset = ($urandom_range(79) == 0);
      cyc(w, a, d);
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 addr  input  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  register write strobe, sampled on rising edge.
REQ-006 wdata  input  32  write data.
REQ-007 rdata  output  32  combinational read of register selected by addr.
REQ-008 irq  output  1  hardware interrupt request, one bit of the CPU HWint vector.

Function
REQ-009 CTRL fields SHALL be bit0 EN, bits2:1 MODE, bit3 IM (interrupt mask); bits31:4 SHALL read 0 and ignore writes.
REQ-010 PRESET SHALL be 32-bit read/write; COUNT SHALL be 32-bit read-only, writes ignored.
REQ-011 rdata SHALL return CTRL (zero-extended), PRESET, COUNT or 0 for addr 0/1/2/3 in the same cycle.
REQ-012 Bus writes SHALL take effect at the edge where we=1.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-014 IDLE: EN=1 -> LOAD; otherwise stay.
REQ-015 LOAD: COUNT<=PRESET; -> CNT.
REQ-016 CNT: EN=0 -> IDLE with COUNT frozen; else COUNT>1 -> COUNT<=COUNT-1, stay; else (COUNT 0 or 1) COUNT<=0, flag<=1, -> INT.
REQ-017 INT with MODE=00: EN<=0, -> IDLE, flag held until cleared by REQ-019.
REQ-018 INT with MODE=01: -> IDLE, EN kept, flag<=0 (flag high exactly one cycle, auto-reload). MODE 10/11 SHALL behave as 00.
REQ-019 Any write to CTRL or PRESET SHALL clear flag at that edge.
REQ-020 irq SHALL equal flag AND IM, registered-flag based, no combinational path from bus inputs.
REQ-021 Simultaneous bus write to CTRL and FSM clearing EN in INT: bus write value SHALL win.
REQ-022 PRESET write during CNT SHALL not alter COUNT until next LOAD.
REQ-023 Latency: EN set at edge N with PRESET=P>=1 -> flag set at edge N+P+2; P=0 -> edge N+3.
REQ-024 MODE=01 steady-state period SHALL be P+3 cycles for P>=1, irq high 1 cycle per period.
REQ-025 COUNT SHALL never wrap below 0.

Reset
REQ-026 reset SHALL set CTRL=0, PRESET=0, COUNT=0, flag=0, state=IDLE; irq=0 and rdata reflects zeroed registers in the following cycle.
REQ-027 reset SHALL override any simultaneous bus write and abort counting in any state.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (2 bits), register word offsets, CTRL bit positions and MODE codes.
REQ-029 Single module, no sub-module; the CPU bridge decodes the base address and drives addr/we.

Verification
REQ-030 PRESET=3, CTRL=0x9 (EN, mode0, IM) at edge N -> COUNT 3,2,1,0 at N+2..N+5; irq=1 from N+5 and held; CTRL reads 0x8.
REQ-031 Continue REQ-030: write CTRL=0x9 -> irq drops the next cycle; new countdown from PRESET=3.
REQ-032 PRESET=2, CTRL=0xB (mode1, IM) -> irq single-cycle pulse every 5 cycles, EN stays 1.
REQ-033 PRESET=0, CTRL=0x1 (IM=0) -> flag set at N+3, irq stays 0; then write CTRL=0x8 -> irq stays 0 (flag cleared by write).
REQ-034 Mid-count: PRESET=10, enable, after COUNT=7 write CTRL=0 -> COUNT frozen at 7, state IDLE; write PRESET=20 -> COUNT still 7; reset mid-count -> all registers 0, irq 0.
REQ-035 Write to addr=2 with 0xFFFFFFFF -> COUNT unchanged; addr=3 read -> 0.
